// File: rtl/mem_port_arbiter3_pkg.sv
// Shared definitions for the 3-port memory arbiter: requester count, mux
// select codes, arbiter states and a modulo-3 index helper.
package mips_bus_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_t;

    function automatic logic [1:0] wrapIdx(input logic [1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        return 2'(sum % NUM_REQ);
    endfunction

endpackage

// File: rtl/mem_port_arbiter3_if.sv
// Request/grant/done bundle between the three requesters, the slave and the
// arbiter; the arbiter connects through the master modport.
interface mem_port_arbiter3_if;
    import mips_bus_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               slv_ready;
    logic [1:0]         sel;
    logic [NUM_REQ-1:0] gnt;
    logic               bus_valid;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] err;

    modport master (
        input  req, slv_ready,
        output sel, gnt, bus_valid, done, err
    );

    modport slave (
        output req, slv_ready,
        input  sel, gnt, bus_valid, done, err
    );

endinterface

// File: rtl/mem_port_arbiter3_rr_pick3.sv
// Combinational 3-way round-robin picker: searches last+1, last+2, last (mod 3)
// and reports the first eligible index.
module rr_pick3
    import mips_bus_pkg::*;
(
    input  logic [2:0] eligible_i,
    input  logic [1:0] last_i,
    output logic       found_o,
    output logic [1:0] idx_o
);

    logic [1:0] cand;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = SEL_REQ0;
        cand    = SEL_REQ0;
        for (int step = NUM_REQ; step >= 1; step--) begin
            cand = wrapIdx(last_i, step);
            if (eligible_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter3.sv
// Round-robin arbiter sharing one 32-bit memory port among three requesters.
// Define ARB_TIMEOUT_EN to abort tenures lasting TIMEOUT_CYCLES busy cycles.
module mem_port_arbiter3
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_port_arbiter3_if.master bus
);

    arbState_t  state_q;
    logic [1:0] sel_q;
    logic [1:0] lastGrant_q;
    logic [2:0] gnt_q;
    logic [2:0] done_q;
    logic       valid_q;
    logic [2:0] eligible;
    logic       pickFound;
    logic [1:0] pickIdx;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || TO_W < 1 || TO_W > 16 ||
        (TIMEOUT_CYCLES - 1) >= (1 << TO_W)) begin : g_badParams
        $error("mem_port_arbiter3: TIMEOUT_CYCLES must be 1..255 and fit in TO_W bits");
    end

`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] timeoutCnt_q;
    logic [TO_W-1:0] timeoutCnt_d;
    logic [2:0]      err_q;

    assign timeoutCnt_d = (timeoutCnt_q == {TO_W{1'b1}}) ? timeoutCnt_q
                                                          : timeoutCnt_q + TO_W'(1);
`endif

    // A requester whose done is pulsing this cycle must not win straight back.
    assign eligible = bus.req & ~done_q;

    rr_pick3 u_pick (
        .eligible_i (eligible),
        .last_i     (lastGrant_q),
        .found_o    (pickFound),
        .idx_o      (pickIdx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= SEL_IDLE;
            gnt_q        <= '0;
            valid_q      <= 1'b0;
            done_q       <= '0;
            lastGrant_q  <= SEL_REQ2;
`ifdef ARB_TIMEOUT_EN
            err_q        <= '0;
            timeoutCnt_q <= '0;
`endif
        end else begin
            done_q <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (pickFound) begin
                        state_q <= BUSY;
                        gnt_q   <= 3'b001 << pickIdx;
                        sel_q   <= pickIdx;
                        valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        timeoutCnt_q <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (bus.slv_ready) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        sel_q       <= SEL_IDLE;
                        valid_q     <= 1'b0;
                        done_q      <= gnt_q;
                        lastGrant_q <= sel_q;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (timeoutCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        sel_q       <= SEL_IDLE;
                        valid_q     <= 1'b0;
                        err_q       <= gnt_q;
                        lastGrant_q <= sel_q;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_d;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.bus_valid = valid_q;
    assign bus.done      = done_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Self-checking bench for mem_port_arbiter3: directed vector table, reset and
// timeout sequences, then random traffic against a request-level model.
module tb_mem_port_arbiter3;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic [2:0] req;
        logic       rdy;
        logic [1:0] eSel;
        logic [2:0] eGnt;
        logic       eValid;
        logic [2:0] eDone;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];

    // Reference model: who owns the port (-1 = nobody), who owned it last,
    // how long the current tenure has run, and this cycle's pulses.
    int         mOwner;
    int         mLast;
    int         mTenure;
    logic [2:0] mDone;
    logic [2:0] mErr;

    mem_port_arbiter3_if bus ();

    mem_port_arbiter3 #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .TO_W           (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // A granted requester must keep its request up until done or err arrives.
    always @(negedge clk) begin
        if (rst_n && bus.gnt != 3'b000) begin
            checks++;
            if ((bus.gnt & ~bus.req) != 3'b000) begin
                errors++;
                $display("[TB] FAIL protocol: gnt=%b but req=%b", bus.gnt, bus.req);
            end
        end
    end

    task automatic addVec(input logic [2:0] r, input logic y, input logic [1:0] s,
                          input logic [2:0] g, input logic v, input logic [2:0] d);
        vec_t e;
        e.req = r; e.rdy = y; e.eSel = s; e.eGnt = g; e.eValid = v; e.eDone = d;
        vecs.push_back(e);
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic y);
        bus.req       = r;
        bus.slv_ready = y;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] eSel, input logic [2:0] eGnt,
                               input logic eValid, input logic [2:0] eDone, input logic [2:0] eErr);
        checks++;
        if (bus.sel !== eSel || bus.gnt !== eGnt || bus.bus_valid !== eValid ||
            bus.done !== eDone || bus.err !== eErr) begin
            errors++;
            $display("[TB] FAIL %s: got sel=%b gnt=%b valid=%b done=%b err=%b, expected sel=%b gnt=%b valid=%b done=%b err=%b",
                     name, bus.sel, bus.gnt, bus.bus_valid, bus.done, bus.err,
                     eSel, eGnt, eValid, eDone, eErr);
        end
    endtask

    task automatic doReset();
        bus.req       = 3'b000;
        bus.slv_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("reset", 2'b11, 3'b000, 1'b0, 3'b000, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic modelReset();
        mOwner  = -1;
        mLast   = 2;
        mTenure = 0;
        mDone   = 3'b000;
        mErr    = 3'b000;
    endtask

    task automatic modelStep(input logic [2:0] r, input logic y);
        logic [2:0] wasDone;
        wasDone = mDone;
        mDone   = 3'b000;
        mErr    = 3'b000;
        if (mOwner < 0) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (mLast + k) % 3;
                if (mOwner < 0 && r[c] && !wasDone[c]) begin
                    mOwner  = c;
                    mTenure = 0;
                end
            end
        end else begin
            mTenure++;
            if (y) begin
                mDone[mOwner] = 1'b1;
                mLast  = mOwner;
                mOwner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (mTenure >= TB_TIMEOUT) begin
                mErr[mOwner] = 1'b1;
                mLast  = mOwner;
                mOwner = -1;
            end
`endif
        end
    endtask

    task automatic checkModel(input string name);
        logic [1:0] eSel;
        logic [2:0] eGnt;
        eSel = (mOwner < 0) ? 2'b11 : 2'(mOwner);
        eGnt = (mOwner < 0) ? 3'b000 : 3'(1 << mOwner);
        checkOutput(name, eSel, eGnt, (mOwner >= 0), mDone, mErr);
    endtask

    initial begin
        logic [2:0] rq;
        logic       rdy;

        bus.req       = 3'b000;
        bus.slv_ready = 1'b0;

        // Single request, ignored ready in IDLE, pointer rotation, done masking, fairness.
        addVec(3'b000, 1'b0, 2'b11, 3'b000, 1'b0, 3'b000);
        addVec(3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000);
        addVec(3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000);
        addVec(3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000);
        addVec(3'b001, 1'b1, 2'b11, 3'b000, 1'b0, 3'b001);
        addVec(3'b000, 1'b1, 2'b11, 3'b000, 1'b0, 3'b000);
        addVec(3'b101, 1'b0, 2'b10, 3'b100, 1'b1, 3'b000);
        addVec(3'b101, 1'b1, 2'b11, 3'b000, 1'b0, 3'b100);
        addVec(3'b101, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000);
        addVec(3'b011, 1'b1, 2'b11, 3'b000, 1'b0, 3'b001);
        addVec(3'b011, 1'b0, 2'b01, 3'b010, 1'b1, 3'b000);
        addVec(3'b011, 1'b1, 2'b11, 3'b000, 1'b0, 3'b010);
        addVec(3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000);
        addVec(3'b001, 1'b1, 2'b11, 3'b000, 1'b0, 3'b001);
        addVec(3'b001, 1'b0, 2'b11, 3'b000, 1'b0, 3'b000);
        addVec(3'b001, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000);
        addVec(3'b001, 1'b1, 2'b11, 3'b000, 1'b0, 3'b001);
        addVec(3'b000, 1'b0, 2'b11, 3'b000, 1'b0, 3'b000);
        addVec(3'b111, 1'b1, 2'b01, 3'b010, 1'b1, 3'b000);
        addVec(3'b111, 1'b1, 2'b11, 3'b000, 1'b0, 3'b010);
        addVec(3'b111, 1'b1, 2'b10, 3'b100, 1'b1, 3'b000);
        addVec(3'b111, 1'b1, 2'b11, 3'b000, 1'b0, 3'b100);
        addVec(3'b111, 1'b1, 2'b00, 3'b001, 1'b1, 3'b000);
        addVec(3'b111, 1'b1, 2'b11, 3'b000, 1'b0, 3'b001);
        addVec(3'b111, 1'b1, 2'b01, 3'b010, 1'b1, 3'b000);
        addVec(3'b111, 1'b1, 2'b11, 3'b000, 1'b0, 3'b010);
        addVec(3'b000, 1'b0, 2'b11, 3'b000, 1'b0, 3'b000);

        @(negedge clk);
        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].eSel, vecs[i].eGnt,
                        vecs[i].eValid, vecs[i].eDone, 3'b000);
        end

        // Reset pulled in the middle of a req1 tenure, then req0 wins first.
        doReset();
        applyStimulus(3'b010, 1'b0);
        checkOutput("rst_grant1", 2'b01, 3'b010, 1'b1, 3'b000, 3'b000);
        applyStimulus(3'b010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid", 2'b11, 3'b000, 1'b0, 3'b000, 3'b000);
        bus.req = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'b111, 1'b0);
        checkOutput("rst_after", 2'b00, 3'b001, 1'b1, 3'b000, 3'b000);
        applyStimulus(3'b111, 1'b1);
        checkOutput("rst_after_done", 2'b11, 3'b000, 1'b0, 3'b001, 3'b000);

        // Slave never answers a req1 tenure.
        doReset();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            applyStimulus(3'b010, 1'b0);
            checkOutput($sformatf("to_busy%0d", i), 2'b01, 3'b010, 1'b1, 3'b000, 3'b000);
        end
        applyStimulus(3'b010, 1'b0);
        checkOutput("to_abort", 2'b11, 3'b000, 1'b0, 3'b000, 3'b010);
        applyStimulus(3'b010, 1'b0);
        checkOutput("to_regrant", 2'b01, 3'b010, 1'b1, 3'b000, 3'b000);
`else
        applyStimulus(3'b010, 1'b0);
        checkOutput("stall_first", 2'b01, 3'b010, 1'b1, 3'b000, 3'b000);
        for (int i = 0; i < 100; i++) applyStimulus(3'b010, 1'b0);
        checkOutput("stall_100", 2'b01, 3'b010, 1'b1, 3'b000, 3'b000);
`endif

        // Random traffic obeying the hold-until-done rule, compared every cycle.
        doReset();
        modelReset();
        rq = 3'b000;
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (rq[r]) begin
                    if (mDone[r] || mErr[r]) rq[r] = ($urandom_range(0, 1) == 1);
                end else begin
                    rq[r] = ($urandom_range(0, 2) == 0);
                end
            end
            rdy = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            applyStimulus(rq, rdy);
            modelStep(rq, rdy);
            checkModel($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter3.md
Name: mem_port_arbiter3

Overview:
Round-robin arbiter that shares the single 32-bit memory/bus port among three requesters (0: instruction fetch, 1: load/store, 2: debug/DMA).
It drives the select of the downstream 3-to-1 32-bit address/data mux and sequences each transaction through a request/grant/done handshake with the slave.
It sits between the pipeline front-ends and the shared memory interface.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles before abort. Used only with the optional feature; range 1..255.
- TO_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  per-requester request level; held high until done or err
- slv_ready  in  1  slave completes the current transfer this cycle
- sel  out  2  mux select: 00=req0, 01=req1, 10=req2, 11=idle (mux outputs 0)
- gnt  out  3  one-hot grant, registered
- bus_valid  out  1  transfer active on the shared port
- done  out  3  one-cycle completion pulse to the granted requester
- err  out  3  one-cycle timeout-abort pulse (optional feature; else 0)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - sel=2'b11, gnt=0, bus_valid=0, done=0, err=0
  - last-grant pointer=2, so req0 has first priority after reset.
  - Asserting reset mid-transfer drops all of the above immediately, with no done pulse.
- States: IDLE and BUSY. All outputs are registered.
- IDLE:
  - Eligible set = req & ~done, i.e. the requester whose done pulses this cycle is masked.
  - If the eligible set is non-empty, pick the first index in the order last+1, last+2, last (mod 3).
  - Next cycle: state=BUSY, gnt=onehot(i), sel=i, bus_valid=1, timeout counter=0.
  - Latency: req sampled in cycle N gives grant visible in cycle N+1.
- BUSY:
  - gnt, sel and bus_valid are held stable.
  - On slv_ready=1, next cycle: state=IDLE, gnt=0, sel=11, bus_valid=0, done=gnt for exactly one cycle, last=i.
  - Re-arbitration happens in that same IDLE cycle, so the next grant appears the cycle after.
  - Minimum tenure is one BUSY cycle; peak rate is one transfer per 2 cycles per port.
- Ignored inputs:
  - slv_ready in IDLE is ignored.
  - req changes during BUSY are ignored; the tenure ends only on slv_ready (or timeout). Dropping req before done is a protocol violation, checked by a bench assertion.
- Invariants:
  - gnt is at most one-hot.
  - sel==11 exactly when gnt==0.
  - done and err are never both non-zero.
  - bus_valid == |gnt.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - The counter increments in every BUSY cycle without slv_ready.
  - When it reaches TIMEOUT_CYCLES-1 with no slv_ready, the next cycle goes IDLE, err=gnt for one cycle, done stays 0, and last=i.
  - slv_ready in the terminal cycle takes precedence and completes normally.
  - The counter saturates; it never wraps.
- Undefined: no counter logic, err tied to 0, and BUSY waits indefinitely.

Decomposition:
- Shared package mips_bus_pkg:
  - NUM_REQ=3
  - SEL_REQ0=2'b00, SEL_REQ1=2'b01, SEL_REQ2=2'b10, SEL_IDLE=2'b11
  - arb state enum {IDLE, BUSY}
- Sub-module rr_pick3: combinational; inputs eligible[2:0] and last[1:0]; outputs found and idx[1:0]. It is reusable by other 3-way arbiters.

Test Plan:
1. Single request:
   - Stimulus: req=001 from cycle 2; slv_ready=1 at cycle 5.
   - Response: cycles 3-5 gnt=001, sel=00, bus_valid=1; cycle 6 done=001, sel=11.
2. Fairness:
   - Stimulus: req=111 held continuously; slv_ready=1 every BUSY cycle; each requester re-raises after its done.
   - Response: grant order 0,1,2,0,1,2 with sel 00,01,10,00; done pulses in the same order.
3. Round-robin pointer:
   - Stimulus: after req0 completes (last=0), raise req=101.
   - Response: req2 granted with sel=10, then req0.
4. Reset mid-transfer:
   - Stimulus: req1 granted; pull rst_n low during BUSY.
   - Response: same-cycle sel=11, gnt=0, done=0. After release, with req=111, req0 is granted first.
5. Timeout, macro defined:
   - Stimulus: TIMEOUT_CYCLES=4; req=010; slv_ready never asserted.
   - Response: 4 BUSY cycles, then err=010 for one cycle, sel=11.
   - Same stimulus with the macro undefined: still BUSY after 100 cycles, err=0.
6. Masking and ignored ready:
   - Stimulus: slv_ready pulsed in IDLE; separately, req0 held high through its done cycle.
   - Response: no state change for the IDLE pulse; req0 is not re-granted in its done cycle when req1 is pending.
